// File: rtl/kuznechik_decipher.sv
// Iterative Kuznechik (GOST R 34.12-2015) block decryptor.
// Applies X[K10], then nine rounds of L^-1 (as 16 serial R^-1 steps),
// S^-1 and X[Ki] for i = 9..1. Fixed latency of 163 cycles from request
// acceptance to valid_o. Round keys are supplied as a parameter so the
// block carries no file dependency; K1 sits in the least significant slot.
module kuznechik_decipher #(
    parameter logic [1279:0] ROUND_KEYS = {
        128'h72e9dd7416bcf45b755dbaa88e4a4043,   // K10
        128'hbb44e25378c73123a5f32f73cdb6e517,   // K9
        128'h5a7925017b9fdd3ed72a91a22286f984,   // K8
        128'h51e640757e8745de705727265a0098b1,   // K7
        128'hbd079435165c6432b532e82834da581b,   // K6
        128'h57646468c44a5e28d3e59246f429f1ac,   // K5
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,   // K4
        128'hdb31485315694343228d6aef8cc78c44,   // K3
        128'hfedcba98765432100123456789abcdef,   // K2
        128'h8899aabbccddeeff0011223344556677    // K1
    }
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic         request_i,
    input  logic         ack_i,
    input  logic [127:0] data_i,
    output logic         busy_o,
    output logic         valid_o,
    output logic [127:0] data_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEY    = 3'd1,
        LINV   = 3'd2,
        SINV   = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Forward S-box pi, entry 0 in the most significant byte.
    localparam logic [2047:0] PI = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D,
        128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F,
        128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC,
        128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1,
        128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903,
        128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641,
        128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789,
        128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52,
        128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    // Coefficients of a14..a0 in the R^-1 feedback byte (a15 has weight 1).
    localparam logic [119:0] L_COEF = {
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
    };

    // Builds pi^-1 at elaboration time in the same MSB-first layout as PI.
    function automatic logic [2047:0] invert_pi(input logic [2047:0] p);
        logic [2047:0] r;
        logic [7:0]    v;
        logic [10:0]   pos;
        r = {2048{1'b0}};
        for (int i = 0; i < 256; i++) begin
            v   = p[(255 - i) * 8 +: 8];
            pos = {~v, 3'b000};
            r[pos +: 8] = i[7:0];
        end
        return r;
    endfunction

    localparam logic [2047:0] PI_INV = invert_pi(PI);

    // Multiply in GF(2^8) modulo x^8+x^7+x^6+x+1; with a constant operand
    // this folds into a fixed XOR network per coefficient.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                p = p ^ x;
            end
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // One inverse linear step: shift left a byte, append the feedback byte.
    function automatic logic [127:0] r_inv(input logic [127:0] a);
        logic [7:0] b;
        b = a[127:120];
        for (int i = 0; i < 15; i++) begin
            b = b ^ gf_mul(a[i * 8 +: 8], L_COEF[i * 8 +: 8]);
        end
        return {a[119:0], b};
    endfunction

    // Inverse S-box lookup for one byte lane.
    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [10:0] pos;
        pos = {~x, 3'b000};
        return PI_INV[pos +: 8];
    endfunction

    // Inverse substitution across all sixteen byte lanes.
    function automatic logic [127:0] s_inv_all(input logic [127:0] a);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i * 8 +: 8] = sbox_inv(a[i * 8 +: 8]);
        end
        return r;
    endfunction

    // Round key selection; index 0 is K1, index 9 is K10.
    function automatic logic [127:0] key_at(input logic [3:0] idx);
        logic [127:0] k;
        case (idx)
            4'd0:    k = ROUND_KEYS[127:0];
            4'd1:    k = ROUND_KEYS[255:128];
            4'd2:    k = ROUND_KEYS[383:256];
            4'd3:    k = ROUND_KEYS[511:384];
            4'd4:    k = ROUND_KEYS[639:512];
            4'd5:    k = ROUND_KEYS[767:640];
            4'd6:    k = ROUND_KEYS[895:768];
            4'd7:    k = ROUND_KEYS[1023:896];
            4'd8:    k = ROUND_KEYS[1151:1024];
            4'd9:    k = ROUND_KEYS[1279:1152];
            default: k = 128'h0;
        endcase
        return k;
    endfunction

    state_t       state_r;
    state_t       state_next_s;
    logic [127:0] work_r;
    logic [3:0]   idx_r;
    logic [3:0]   ctr_r;
    logic [127:0] key_xor_s;

    assign key_xor_s = work_r ^ key_at(idx_r);

    // State register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (request_i) begin
                    state_next_s = KEY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            KEY: begin
                if (idx_r == 4'd0) begin
                    state_next_s = FINISH;
                end else begin
                    state_next_s = LINV;
                end
            end
            LINV: begin
                if (ctr_r == 4'd15) begin
                    state_next_s = SINV;
                end else begin
                    state_next_s = LINV;
                end
            end
            SINV: begin
                state_next_s = KEY;
            end
            FINISH: begin
                if (ack_i && request_i) begin
                    state_next_s = KEY;
                end else if (ack_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FINISH;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath, round index, step counter and registered host outputs.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            work_r  <= 128'h0;
            idx_r   <= 4'd9;
            ctr_r   <= 4'd0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= 128'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (request_i) begin
                        work_r <= data_i;
                        idx_r  <= 4'd9;
                        busy_o <= 1'b1;
                    end
                end
                KEY: begin
                    work_r <= key_xor_s;
                    if (idx_r == 4'd0) begin
                        data_o  <= key_xor_s;
                        valid_o <= 1'b1;
                    end else begin
                        idx_r <= idx_r - 4'd1;
                        ctr_r <= 4'd0;
                    end
                end
                LINV: begin
                    work_r <= r_inv(work_r);
                    ctr_r  <= ctr_r + 4'd1;
                end
                SINV: begin
                    work_r <= s_inv_all(work_r);
                end
                FINISH: begin
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        if (request_i) begin
                            work_r <= data_i;
                            idx_r  <= 4'd9;
                        end else begin
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
